debug_step_ctrl: RTL and testbench

Upstream debug front-end for the FPGA board interface. It converts a bouncing pushbutton into exactly one CPU clock-enable pulse per press and supports free-run mode. After each step it freezes per-stage PC/opcode snapshots and a saturated register value. These snapshots are the stable inputs the HEX/LEDR display block renders, so the display never sees mid-update values.

---
 rtl/debug_pkg.sv | 35 +++
 rtl/debug_step_ctrl_if.sv | 28 ++
 rtl/debug_step_ctrl_debouncer.sv | 55 +++++
 rtl/debug_step_ctrl.sv | 154 +++++++++++++++
 tb/tb_debug_step_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/debug_pkg.sv
// Shared types and constants for the debug step controller.
// Stage indices, controller state encoding, display saturation limit.
package debug_pkg;

  localparam int NUM_STAGES = 7;

  typedef enum logic [2:0] {
    FETCH,
    FETCH_WAIT,
    DECODE,
    EXECUTE,
    MEMORY,
    MEMORY_WAIT,
    WRITEBACK
  } stage_e;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    STEP,
    CAPTURE,
    WAIT_REL,
    RUN
  } step_state_e;

  localparam logic [19:0] DISPLAY_MAX = 20'd999999;

  typedef logic [6:0] stage_word_t;

  // Clamp a register value to what six decimal HEX digits can show.
  function automatic logic [19:0] saturate_display(input logic [31:0] value);
    return (value >= {12'd0, DISPLAY_MAX}) ? DISPLAY_MAX : value[19:0];
  endfunction

endpackage

// File: rtl/debug_step_ctrl_if.sv
// CPU-side debug bus: per-stage PC/opcode, register debug read port and
// the pipeline clock enable. The controller uses the slave view.
interface debug_step_ctrl_if;
  import debug_pkg::*;

  stage_word_t [NUM_STAGES-1:0] pc_in;
  stage_word_t [NUM_STAGES-1:0] opcode_in;
  logic [31:0]                  reg_rdata;
  logic [3:0]                   reg_raddr;
  logic                         cpu_en;

  modport master (
    output pc_in,
    output opcode_in,
    output reg_rdata,
    input  reg_raddr,
    input  cpu_en
  );

  modport slave (
    input  pc_in,
    input  opcode_in,
    input  reg_rdata,
    output reg_raddr,
    output cpu_en
  );

endinterface

// File: rtl/debug_step_ctrl_debouncer.sv
// key_debouncer: synchronizes the raw active-low pushbutton and counts how
// long the synchronized level has been stable in the phase the controller
// asks for (pressed while debouncing a press, released while waiting for
// release). press_done / release_done fire when the level has held for
// DEBOUNCE_CYCLES cycles.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_step_n,
  input  logic press_mode,
  input  logic release_mode,
  output logic key_p,
  output logic press_done,
  output logic release_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_meta;
  logic             key_sync;
  logic [CNT_W-1:0] cnt;
  logic             level_ok;

  // Two-flop synchronizer; idles at the released (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_step_n;
      key_sync <= key_meta;
    end
  end

  assign key_p    = ~key_sync;
  assign level_ok = (press_mode && key_p) || (release_mode && !key_p);

  // Stability counter: runs while the wanted level holds, clears otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (level_ok && (cnt != CNT_LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end else if (!level_ok) begin
      cnt <= '0;
    end
  end

  assign press_done   = press_mode && key_p && (cnt == CNT_LAST);
  assign release_done = release_mode && !key_p && (cnt == CNT_LAST);

endmodule

// File: rtl/debug_step_ctrl.sv
// debug_step_ctrl: turns a bouncing pushbutton into one CPU clock-enable
// pulse per press, supports free-run, and freezes per-stage PC/opcode and
// a saturated register value for the display after each step.
// Optional feature macro: DEBUG_STEP_BREAKPOINT_EN (PC breakpoint in RUN).
module debug_step_ctrl
  import debug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_step_n,
  input  logic                         run_sw,
  input  logic [3:0]                   reg_sel,
`ifdef DEBUG_STEP_BREAKPOINT_EN
  input  stage_word_t                  bp_pc,
  input  logic                         bp_valid,
`endif
  debug_step_ctrl_if.slave             cpu,
  output logic                         halted,
  output stage_word_t [NUM_STAGES-1:0] pc_snap,
  output stage_word_t [NUM_STAGES-1:0] opcode_snap,
  output logic [19:0]                  selected_reg_value,
  output logic [15:0]                  step_count
);

  step_state_e state;
  step_state_e next_state;

  logic run_meta;
  logic run_s;
  logic key_p;
  logic press_done;
  logic release_done;
  logic from_run;
  logic bp_match;
  logic bp_freeze;
  logic run_allowed;
  logic snap_load;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_key_debouncer (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_step_n   (key_step_n),
    .press_mode   (state == DB_PRESS),
    .release_mode (state == WAIT_REL),
    .key_p        (key_p),
    .press_done   (press_done),
    .release_done (release_done)
  );

  // Two-flop synchronizer for the free-run switch; idles in single-step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_meta <= 1'b0;
      run_s    <= 1'b0;
    end else begin
      run_meta <= run_sw;
      run_s    <= run_meta;
    end
  end

`ifdef DEBUG_STEP_BREAKPOINT_EN
  logic bp_lock;

  assign bp_match = bp_valid && (cpu.pc_in[FETCH] == bp_pc);

  // Breakpoint lock blocks RUN re-entry until run_s has been seen low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_lock   <= 1'b0;
      bp_freeze <= 1'b0;
    end else begin
      bp_freeze <= (state == RUN) && bp_match;
      if (!run_s) begin
        bp_lock <= 1'b0;
      end else if ((state == RUN) && bp_match) begin
        bp_lock <= 1'b1;
      end
    end
  end

  assign run_allowed = run_s && !bp_lock;
`else
  assign bp_match    = 1'b0;
  assign bp_freeze   = 1'b0;
  assign run_allowed = run_s;
`endif

  // Next-state logic; an active run switch overrides any step in progress.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (key_p) next_state = DB_PRESS;
      DB_PRESS: begin
        if (!key_p)          next_state = IDLE;
        else if (press_done) next_state = STEP;
      end
      STEP:     next_state = CAPTURE;
      CAPTURE: begin
        if (from_run) next_state = key_p ? WAIT_REL : IDLE;
        else          next_state = WAIT_REL;
      end
      WAIT_REL: if (release_done) next_state = IDLE;
      RUN:      if (!run_s || bp_match) next_state = CAPTURE;
      default:  next_state = IDLE;
    endcase
    if (run_allowed && (state != RUN)) next_state = RUN;
  end

  // State register plus glitch-free registered cpu_en / halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      from_run      <= 1'b0;
      cpu.cpu_en    <= 1'b0;
      halted        <= 1'b1;
      cpu.reg_raddr <= 4'd0;
    end else begin
      state         <= next_state;
      from_run      <= (state == RUN);
      cpu.cpu_en    <= (next_state == STEP) || (next_state == RUN);
      halted        <= (next_state != RUN);
      cpu.reg_raddr <= reg_sel;
    end
  end

  // After a breakpoint the RUN reload already holds the matching cycle.
  assign snap_load = (state == RUN) || ((state == CAPTURE) && !bp_freeze);

  // Snapshot registers the display reads; only a completed single step counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_snap            <= '0;
      opcode_snap        <= '0;
      selected_reg_value <= '0;
      step_count         <= '0;
    end else begin
      if (snap_load) begin
        pc_snap            <= cpu.pc_in;
        opcode_snap        <= cpu.opcode_in;
        selected_reg_value <= saturate_display(cpu.reg_rdata);
      end
      if ((state == CAPTURE) && !from_run) begin
        step_count <= step_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Directed testbench for debug_step_ctrl with DEBOUNCE_CYCLES=4.
module tb_debug_step_ctrl;
  import debug_pkg::*;

  localparam int DB = 4;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b1;
  logic                         key_step_n;
  logic                         run_sw;
  logic [3:0]                   reg_sel;
  logic                         halted;
  stage_word_t [NUM_STAGES-1:0] pc_snap;
  stage_word_t [NUM_STAGES-1:0] opcode_snap;
  logic [19:0]                  selected_reg_value;
  logic [15:0]                  step_count;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int pulses      = 0;
  int last_pulse  = -1;
  int c0;

  debug_step_ctrl_if dbg ();

`ifdef DEBUG_STEP_BREAKPOINT_EN
  stage_word_t bp_pc    = 7'd12;
  logic        bp_valid = 1'b0;
`endif

  debug_step_ctrl #(
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .key_step_n         (key_step_n),
    .run_sw             (run_sw),
    .reg_sel            (reg_sel),
`ifdef DEBUG_STEP_BREAKPOINT_EN
    .bp_pc              (bp_pc),
    .bp_valid           (bp_valid),
`endif
    .cpu                (dbg),
    .halted             (halted),
    .pc_snap            (pc_snap),
    .opcode_snap        (opcode_snap),
    .selected_reg_value (selected_reg_value),
    .step_count         (step_count)
  );

  always #5 clk = ~clk;

  // Distinct per-cycle pattern for all seven stages.
  function automatic logic [48:0] make_word(input int c, input logic [6:0] salt);
    logic [48:0] w;
    w = '0;
    for (int i = 0; i < 7; i++) w[i*7 +: 7] = 7'(c * 3 + i) ^ salt;
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, count cpu_en pulses, and move the pipeline values.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (dbg.cpu_en === 1'b1) begin
        pulses++;
        last_pulse = cyc;
      end
      dbg.pc_in     = make_word(cyc, 7'h00);
      dbg.opcode_in = make_word(cyc, 7'h55);
    end
  endtask

  initial begin
    logic [31:0] sat_in  [5];
    logic [19:0] sat_exp [5];
    int          c1;
    int          c2;
    sat_in[0] = 32'd999998;   sat_exp[0] = 20'd999998;
    sat_in[1] = 32'd999999;   sat_exp[1] = 20'd999999;
    sat_in[2] = 32'd1000000;  sat_exp[2] = 20'd999999;
    sat_in[3] = 32'd1234567;  sat_exp[3] = 20'd999999;
    sat_in[4] = 32'hFFFFFFFF; sat_exp[4] = 20'd999999;

    key_step_n    = 1'b1;
    run_sw        = 1'b0;
    reg_sel       = 4'h0;
    dbg.reg_rdata = 32'd1234567;
    dbg.pc_in     = make_word(0, 7'h00);
    dbg.opcode_in = make_word(0, 7'h55);

    $display("[TB] reset values");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_cpu_en", 64'(dbg.cpu_en), 64'(0));
    checkOutput("rst_halted", 64'(halted), 64'(1));
    checkOutput("rst_raddr", 64'(dbg.reg_raddr), 64'(0));
    checkOutput("rst_pc_snap", 64'(pc_snap), 64'(0));
    checkOutput("rst_sel", 64'(selected_reg_value), 64'(0));
    checkOutput("rst_step_count", 64'(step_count), 64'(0));
    applyStimulus(2);
    rst_n   = 1'b0 | 1'b1;
    reg_sel = 4'hA;
    applyStimulus(2);
    checkOutput("raddr", 64'(dbg.reg_raddr), 64'hA);

    $display("[TB] single held press");
    c0 = cyc;
    pulses = 0;
    last_pulse = -1;
    key_step_n = 1'b0;
    applyStimulus(20);
    checkOutput("held_pulses", 64'(pulses), 64'(1));
    checkOutput("press_latency", 64'(last_pulse), 64'(c0 + 7));
    checkOutput("step_count_1", 64'(step_count), 64'(1));
    checkOutput("pc_snap_1", 64'(pc_snap), 64'(make_word(c0 + 8, 7'h00)));
    checkOutput("opcode_snap_1", 64'(opcode_snap), 64'(make_word(c0 + 8, 7'h55)));
    checkOutput("sel_sat_1", 64'(selected_reg_value), 64'(999999));
    key_step_n = 1'b1;
    applyStimulus(10);
    checkOutput("halted_step", 64'(halted), 64'(1));

    $display("[TB] bounce");
    pulses = 0;
    key_step_n = 1'b0; applyStimulus(2);
    key_step_n = 1'b1; applyStimulus(1);
    key_step_n = 1'b0; applyStimulus(2);
    key_step_n = 1'b1; applyStimulus(15);
    checkOutput("bounce_pulses", 64'(pulses), 64'(0));
    checkOutput("bounce_count", 64'(step_count), 64'(1));

    $display("[TB] three clean presses");
    for (int p = 0; p < 3; p++) begin
      pulses = 0;
      key_step_n = 1'b0;
      applyStimulus(10);
      checkOutput("clean_pulse", 64'(pulses), 64'(1));
      key_step_n = 1'b1;
      applyStimulus(10);
    end
    checkOutput("step_count_4", 64'(step_count), 64'(4));
    checkOutput("pc_snap_last", 64'(pc_snap), 64'(make_word(last_pulse + 1, 7'h00)));

    $display("[TB] free run");
    dbg.reg_rdata = 32'd5;
    c1 = cyc;
    run_sw = 1'b1;
    applyStimulus(2);
    checkOutput("run_pre_en", 64'(dbg.cpu_en), 64'(0));
    checkOutput("run_pre_halted", 64'(halted), 64'(1));
    applyStimulus(1);
    checkOutput("run_en", 64'(dbg.cpu_en), 64'(1));
    checkOutput("run_halted", 64'(halted), 64'(0));
    applyStimulus(1);
    checkOutput("run_track", 64'(pc_snap), 64'(make_word(c1 + 3, 7'h00)));
    checkOutput("run_sel_small", 64'(selected_reg_value), 64'(5));
    for (int s = 0; s < 5; s++) begin
      dbg.reg_rdata = sat_in[s];
      applyStimulus(1);
      checkOutput("sat", 64'(selected_reg_value), 64'(sat_exp[s]));
      checkOutput("run_track_loop", 64'(pc_snap), 64'(make_word(cyc - 1, 7'h00)));
    end
    checkOutput("run_count", 64'(step_count), 64'(4));

    c2 = cyc;
    run_sw = 1'b0;
    dbg.reg_rdata = 32'd42;
    applyStimulus(2);
    checkOutput("run_tail_en", 64'(dbg.cpu_en), 64'(1));
    applyStimulus(1);
    checkOutput("run_stop_en", 64'(dbg.cpu_en), 64'(0));
    checkOutput("run_stop_halted", 64'(halted), 64'(1));
    applyStimulus(3);
    checkOutput("final_pc_snap", 64'(pc_snap), 64'(make_word(c2 + 3, 7'h00)));
    checkOutput("final_sel", 64'(selected_reg_value), 64'(42));
    checkOutput("final_count", 64'(step_count), 64'(4));

    $display("[TB] reset during debounce");
    pulses = 0;
    key_step_n = 1'b0;
    applyStimulus(4);
    rst_n = 1'b0;
    key_step_n = 1'b1;
    #1;
    checkOutput("mid_rst_en", 64'(dbg.cpu_en), 64'(0));
    checkOutput("mid_rst_halted", 64'(halted), 64'(1));
    checkOutput("mid_rst_raddr", 64'(dbg.reg_raddr), 64'(0));
    checkOutput("mid_rst_pc", 64'(pc_snap), 64'(0));
    checkOutput("mid_rst_op", 64'(opcode_snap), 64'(0));
    checkOutput("mid_rst_sel", 64'(selected_reg_value), 64'(0));
    checkOutput("mid_rst_count", 64'(step_count), 64'(0));
    applyStimulus(2);
    rst_n = 1'b1;
    applyStimulus(12);
    checkOutput("post_rst_pulses", 64'(pulses), 64'(0));
    checkOutput("post_rst_count", 64'(step_count), 64'(0));
    checkOutput("post_rst_raddr", 64'(dbg.reg_raddr), 64'hA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
